vx_gbar_unit: RTL and testbench

- Global barrier responder: the completion end of the gbar bus that each socket drives as master through its core-level gbar arbiter.
- Sits at cluster/top level and collects barrier arrivals from all cores, identified by global core id.
- When the declared number of cores has arrived at a barrier id, broadcasts a one-cycle release response and clears that barrier's state.
- Per-barrier arrival masks also detect protocol errors.

---
 rtl/vx_gbar_unit.sv | 110 +++++++++++
 tb/tb_vx_gbar_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vx_gbar_unit.sv
// Global barrier responder: collects per-core arrivals on each barrier id and
// broadcasts a one-cycle release when the declared number of cores has arrived.
module vx_gbar_unit #(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 8,
    parameter int BAR_ID_W     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int CORE_ID_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [BAR_ID_W-1:0]  req_id,
    input  logic [CORE_ID_W-1:0] req_size_m1,
    input  logic [CORE_ID_W-1:0] req_core_id,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [BAR_ID_W-1:0]  rsp_id,
    output logic                 err_dup,
    output logic                 err_size,
    output logic                 busy
);

    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] r_mask;
    logic [NUM_BARRIERS-1:0][CORE_ID_W:0]   r_cnt;
    logic [NUM_BARRIERS-1:0][CORE_ID_W-1:0] r_size;
    logic                                   r_active;
    logic                                   r_rsp_valid;
    logic [BAR_ID_W-1:0]                    r_rsp_id;
    logic                                   r_err_dup;
    logic                                   r_err_size;

    logic                    w_id_ok;
    logic                    w_core_ok;
    logic                    w_acc;
    logic                    w_pend_b;
    logic                    w_dup;
    logic                    w_size_mis;
    logic [CORE_ID_W-1:0]    w_s;
    logic                    w_done;
    logic [NUM_BARRIERS-1:0] w_pend;

    assign w_id_ok   = ({1'b0, req_id} < (BAR_ID_W+1)'(NUM_BARRIERS));
    assign w_core_ok = ({1'b0, req_core_id} < (CORE_ID_W+1)'(NUM_CORES));

    // Stall only a request hitting the barrier being released this cycle, so a
    // re-arrival cannot merge with the state that is being cleared.
    assign req_ready = r_active & ~(r_rsp_valid & (r_rsp_id == req_id));
    assign w_acc     = req_valid & req_ready;

    assign w_pend_b   = (r_cnt[req_id] != '0);
    assign w_dup      = r_mask[req_id][req_core_id];
    assign w_size_mis = w_pend_b & (req_size_m1 != r_size[req_id]);
    assign w_s        = w_pend_b ? r_size[req_id] : req_size_m1;
    assign w_done     = (r_cnt[req_id] == {1'b0, w_s});

    always_comb begin
        w_pend = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_pend[b] = (r_cnt[b] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_err_dup   <= 1'b0;
            r_err_size  <= 1'b0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
        end else begin
            r_active    <= 1'b1;
            r_rsp_valid <= 1'b0;
            // Out-of-range ids are accepted and dropped without touching state.
            if (w_acc && w_id_ok && w_core_ok) begin
                if (w_dup) begin
                    r_err_dup <= 1'b1;
                end else begin
                    if (w_size_mis) begin
                        r_err_size <= 1'b1;
                    end
                    if (!w_pend_b) begin
                        r_size[req_id] <= req_size_m1;
                    end
                    if (w_done) begin
                        r_rsp_valid    <= 1'b1;
                        r_rsp_id       <= req_id;
                        r_mask[req_id] <= '0;
                        r_cnt[req_id]  <= '0;
                    end else begin
                        r_mask[req_id][req_core_id] <= 1'b1;
                        r_cnt[req_id]               <= r_cnt[req_id] + (CORE_ID_W+1)'(1);
                    end
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign err_dup   = r_err_dup;
    assign err_size  = r_err_size;
    assign busy      = |w_pend;

    a_req_range: assert property (@(posedge clk) disable iff (!reset)
        (req_valid && req_ready) |-> (w_id_ok && w_core_ok));

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Directed bench for vx_gbar_unit: release responses are scoreboarded per cycle,
// status outputs are checked at fixed points of a linear stimulus sequence.
module tb_vx_gbar_unit;

    localparam int NB  = 4;
    localparam int NC  = 8;
    localparam int BW  = 2;
    localparam int CW  = 3;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic [BW-1:0] req_id;
    logic [CW-1:0] req_size_m1;
    logic [CW-1:0] req_core_id;
    logic          req_ready;
    logic          rsp_valid;
    logic [BW-1:0] rsp_id;
    logic          err_dup;
    logic          err_size;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Released barrier ids expected in the cycle right after the accepting edge.
    logic [BW-1:0] sb[$];

    vx_gbar_unit #(
        .NUM_BARRIERS(NB),
        .NUM_CORES   (NC),
        .BAR_ID_W    (BW),
        .CORE_ID_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_size_m1(req_size_m1),
        .req_core_id(req_core_id),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .err_dup    (err_dup),
        .err_size   (err_size),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [BW-1:0] exp_id;
            exp_id = sb.pop_front();
            check("rsp_valid_pulse", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(exp_id));
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
    end

    // One request per cycle: drive after the edge, confirm ready, accept on the edge.
    task automatic send(input int id, input int sz, input int core, input bit rel);
        req_valid   = 1'b1;
        req_id      = BW'(id);
        req_size_m1 = CW'(sz);
        req_core_id = CW'(core);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        if (rel) sb.push_back(BW'(id));
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_id      = '0;
        req_size_m1 = '0;
        req_core_id = '0;

        // Reset held for three cycles, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_dup", 32'(err_dup), 32'd0);
        check("rst_err_size", 32'(err_size), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Four-core barrier on id 2.
        send(2, 3, 0, 1'b0);
        check("b4_busy_first", 32'(busy), 32'd1);
        send(2, 3, 5, 1'b0);
        send(2, 3, 1, 1'b0);
        send(2, 3, 7, 1'b1);
        check("b4_busy_after", 32'(busy), 32'd0);
        // Same id during its release cycle must be stalled (would release if taken).
        req_valid   = 1'b1;
        req_id      = 2'd2;
        req_size_m1 = 3'd0;
        req_core_id = 3'd3;
        #1;
        check("stall_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1;
        check("ready_after_stall", 32'(req_ready), 32'd1);

        // Single-core barrier: immediate release, never pending.
        send(0, 0, 3, 1'b1);
        check("single_busy", 32'(busy), 32'd0);
        idle(1);

        // Duplicate arrival on id 1.
        send(1, 2, 4, 1'b0);
        check("dup_err_before", 32'(err_dup), 32'd0);
        send(1, 2, 4, 1'b0);
        check("dup_err_set", 32'(err_dup), 32'd1);
        check("dup_busy", 32'(busy), 32'd1);
        send(1, 2, 2, 1'b0);
        send(1, 2, 6, 1'b1);
        check("dup_busy_after", 32'(busy), 32'd0);
        idle(1);

        // Size mismatch with interleaved ids and back-to-back releases.
        check("size_err_before", 32'(err_size), 32'd0);
        send(1, 1, 0, 1'b0);
        send(3, 1, 2, 1'b0);
        send(1, 2, 1, 1'b1);
        check("size_err_set", 32'(err_size), 32'd1);
        send(3, 1, 5, 1'b1);
        check("size_busy_after", 32'(busy), 32'd0);
        check("err_dup_sticky", 32'(err_dup), 32'd1);
        idle(2);

        // Asynchronous reset in the middle of a pending barrier.
        send(0, 3, 0, 1'b0);
        send(0, 3, 1, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err_dup", 32'(err_dup), 32'd0);
        check("arst_err_size", 32'(err_size), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        send(0, 3, 2, 1'b0);
        send(0, 3, 3, 1'b0);
        check("post_rst_busy", 32'(busy), 32'd1);
        // Earlier cores 0,1 were discarded, so they count again and complete at two more.
        send(0, 3, 0, 1'b0);
        send(0, 3, 1, 1'b1);
        check("post_rst_busy_done", 32'(busy), 32'd0);
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
